// File: rtl/counter_xn_pkg.sv
// ---------------------------------------------------------------------------
// counter_xn_pkg
// Shared definitions for the counter_xn timer peripheral.
//   mode_e      : channel operating modes (2-bit control field)
//   CTL_IEN_BIT : position of the interrupt-enable bit in the control word
//   CTL_W       : width of the control word {ien, mode[1:0]}
//   MODE_RESET  : mode a channel wakes up in (stopped)
// ---------------------------------------------------------------------------
package counter_xn_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_STOP     = 2'b11
    } mode_e;

    localparam int    CTL_W       = 3;
    localparam int    CTL_IEN_BIT = 2;
    localparam mode_e MODE_RESET  = MODE_STOP;

endpackage

// File: rtl/counter_xn_ch.sv
// ---------------------------------------------------------------------------
// counter_xn_ch
// One timer channel: tick edge detect, count/reload, mode, interrupt enable,
// sticky pending bit and output level.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   tick_i    : slow count source, rising edges are counted
//   we_i      : load strobe already decoded for this channel
//   ctl_we_i  : control strobe already decoded for this channel
//   wdata_i   : load value for count and reload
//   ctl_i     : control word {ien, mode[1:0]}
//   clr_i     : write-1-to-clear for the pending bit
//   count_o   : current count
//   cnt_out_o : output level (one-shot level / periodic pulse / square wave)
//   pend_o    : sticky pending bit
//   ien_o     : interrupt enable
// ---------------------------------------------------------------------------
module counter_xn_ch
    import counter_xn_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             we_i,
    input  logic             ctl_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [CTL_W-1:0] ctl_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             cnt_out_o,
    output logic             pend_o,
    output logic             ien_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             tick_q;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    mode_e            mode_q,   mode_d;
    logic             ien_q,    ien_d;
    logic             pend_q,   pend_d;
    logic             out_q,    out_d;
    logic             edge_w;
    logic             fire;

    assign edge_w = tick_i & ~tick_q;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        ien_d    = ien_q;
        out_d    = out_q;
        fire     = 1'b0;

        // The periodic output is a single-clock pulse, so it falls back to
        // low on every cycle that does not carry a terminal event.
        if (mode_q == MODE_PERIODIC) begin
            out_d = 1'b0;
        end

        // A load on the same cycle discards the edge entirely.
        if (edge_w && !we_i) begin
            case (mode_q)
                MODE_ONESHOT: begin
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else if (count_q == ONE) begin
                        count_d = '0;
                        out_d   = 1'b1;
                        fire    = 1'b1;
                    end
                end
                MODE_PERIODIC, MODE_SQUARE: begin
                    // count==0 (reload of 0) is idle: nothing decrements past 0.
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else if (count_q == ONE) begin
                        count_d = reload_q;
                        fire    = 1'b1;
                        out_d   = (mode_q == MODE_PERIODIC) ? 1'b1 : ~out_q;
                    end
                end
                default: ;
            endcase
        end

        // The edge above was evaluated under the old mode; the new mode only
        // applies from the next cycle on.
        if (ctl_we_i) begin
            mode_d = mode_e'(ctl_i[1:0]);
            ien_d  = ctl_i[CTL_IEN_BIT];
            out_d  = 1'b0;
        end

        if (we_i) begin
            count_d  = wdata_i;
            reload_d = wdata_i;
            out_d    = 1'b0;
        end

        // A new event wins over a simultaneous clear.
        pend_d = fire | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q   <= 1'b0;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= MODE_RESET;
            ien_q    <= 1'b0;
            pend_q   <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            tick_q   <= tick_i;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            ien_q    <= ien_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
        end
    end

    assign count_o   = count_q;
    assign cnt_out_o = out_q;
    assign pend_o    = pend_q;
    assign ien_o     = ien_q;

endmodule

// File: rtl/counter_xn.sv
// ---------------------------------------------------------------------------
// counter_xn
// N-channel programmable down-counter/timer with interrupt support.
// Ports:
//   clk     : system clock
//   RSTN    : asynchronous active-low reset
//   tick    : per-channel count source (rising edge counted)
//   we      : load strobe for channel ch (count and reload <= wdata)
//   ctl_we  : control strobe for channel ch (mode/ien <= ctl_in)
//   ch      : target channel for we/ctl_we (out-of-range is ignored)
//   wdata   : load value
//   ctl_in  : control word {ien, mode[1:0]}
//   rd_ch   : readback channel select
//   irq_clr : write-1-to-clear pending mask
//   rd_data : count[rd_ch], registered (0 when rd_ch is out of range)
//   cnt_out : per-channel output level
//   pend    : sticky pending bits
//   irq     : OR of pending bits whose interrupt is enabled
// ---------------------------------------------------------------------------
module counter_xn
    import counter_xn_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [N_CH-1:0]  tick,
    input  logic             we,
    input  logic             ctl_we,
    input  logic [CH_W-1:0]  ch,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CTL_W-1:0] ctl_in,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [N_CH-1:0]  irq_clr,
    output logic [WIDTH-1:0] rd_data,
    output logic [N_CH-1:0]  cnt_out,
    output logic [N_CH-1:0]  pend,
    output logic             irq
);

    logic [WIDTH-1:0] count_w [N_CH];
    logic [N_CH-1:0]  ien_w;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Only indices below N_CH exist here, so an out-of-range ch never matches
    // any channel and its strobes fall on the floor.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic hit;
        assign hit = (ch == CH_W'(gi));

        counter_xn_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (RSTN),
            .tick_i    (tick[gi]),
            .we_i      (we & hit),
            .ctl_we_i  (ctl_we & hit),
            .wdata_i   (wdata),
            .ctl_i     (ctl_in),
            .clr_i     (irq_clr[gi]),
            .count_o   (count_w[gi]),
            .cnt_out_o (cnt_out[gi]),
            .pend_o    (pend[gi]),
            .ien_o     (ien_w[gi])
        );
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_data_d = count_w[i];
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = |(pend & ien_w);

endmodule
